// File: rtl/servo_pwm_multi_if.sv
// Pulse-width write port for servo_pwm_multi: valid/ready handshake carrying channel index and width.
interface servo_pwm_multi_if #(
    parameter int CH_W  = 2,
    parameter int CNT_W = 20
);
    logic             wr_valid;
    logic             wr_ready;
    logic [CH_W-1:0]  wr_ch;
    logic [CNT_W-1:0] wr_data;

    modport master (output wr_valid, output wr_ch, output wr_data, input  wr_ready);
    modport slave  (input  wr_valid, input  wr_ch, input  wr_data, output wr_ready);
endinterface

// File: rtl/servo_pwm_multi.sv
// Multi-channel servo PWM: shared period counter, shadowed per-channel widths applied at period boundaries.
// Optional SERVO_PWM_RAMP_EN limits each boundary update of a channel's active width to RAMP_STEP.
module servo_pwm_multi #(
    parameter int NUM_CH    = 4,
    parameter int CH_W      = 2,
    parameter int CNT_W     = 20,
    parameter int PERIOD    = 1000000,
    parameter int MIN_PW    = 50000,
    parameter int MAX_PW    = 100000,
    parameter int RAMP_STEP = 500
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    servo_pwm_multi_if.slave    wr,
    output logic [NUM_CH-1:0]   pwm_out,
    output logic                period_start
);
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0] PW_MIN   = CNT_W'(MIN_PW);
    localparam logic [CNT_W-1:0] PW_MAX   = CNT_W'(MAX_PW);

    if ((MIN_PW > MAX_PW) || (MAX_PW >= PERIOD) || (PERIOD < 2) || (RAMP_STEP < 1)
        || (NUM_CH < 1) || (NUM_CH > 16) || ((1 << CH_W) < NUM_CH)) begin : g_bad_params
        $error("servo_pwm_multi: inconsistent parameters");
    end

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] shadow_q [NUM_CH];
    logic [CNT_W-1:0] shadow_d [NUM_CH];
    logic [CNT_W-1:0] active_q [NUM_CH];
    logic [CNT_W-1:0] active_d [NUM_CH];
    logic [NUM_CH-1:0] pwm_q, pwm_d;
    logic             ps_q, ps_d;

    logic             at_last;
    logic             wr_fire;
    logic [CNT_W-1:0] wr_clamped;

`ifdef SERVO_PWM_RAMP_EN
    localparam logic [CNT_W-1:0] PW_STEP = CNT_W'(RAMP_STEP);

    // Off-to-on and on-to-off transitions skip the ramp so a channel never creeps up from zero.
    function automatic logic [CNT_W-1:0] ramp_next(input logic [CNT_W-1:0] cur,
                                                   input logic [CNT_W-1:0] tgt);
        logic [CNT_W-1:0] res;
        if ((tgt == '0) || (cur == '0)) begin
            res = tgt;
        end else if (tgt > cur) begin
            res = ((tgt - cur) <= PW_STEP) ? tgt : (cur + PW_STEP);
        end else begin
            res = ((cur - tgt) <= PW_STEP) ? tgt : (cur - PW_STEP);
        end
        return res;
    endfunction
`endif

    assign at_last     = (state_q == ST_RUN) && (cnt_q == CNT_LAST);
    assign wr.wr_ready = !at_last;
    assign wr_fire     = wr.wr_valid && !at_last;

    always_comb begin
        if (wr.wr_data == '0) begin
            wr_clamped = '0;
        end else if (wr.wr_data < PW_MIN) begin
            wr_clamped = PW_MIN;
        end else if (wr.wr_data > PW_MAX) begin
            wr_clamped = PW_MAX;
        end else begin
            wr_clamped = wr.wr_data;
        end
    end

    // Out-of-range channel indices match no entry, so the write completes and is dropped.
    always_comb begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            shadow_d[i] = shadow_q[i];
            if (wr_fire && (wr.wr_ch == CH_W'(i))) begin
                shadow_d[i] = wr_clamped;
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            active_d[i] = active_q[i];
            if (state_q == ST_IDLE) begin
                if (enable) begin
                    active_d[i] = shadow_q[i];
                end
            end else if (at_last) begin
`ifdef SERVO_PWM_RAMP_EN
                active_d[i] = ramp_next(active_q[i], shadow_q[i]);
`else
                active_d[i] = shadow_q[i];
`endif
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pwm_d   = '0;
        ps_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (enable) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = at_last ? '0 : (cnt_q + CNT_W'(1));
                    ps_d  = (cnt_q == '0);
                    for (int unsigned i = 0; i < NUM_CH; i++) begin
                        pwm_d[i] = (cnt_q < active_q[i]);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pwm_q   <= '0;
            ps_q    <= 1'b0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pwm_q   <= pwm_d;
            ps_q    <= ps_d;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                shadow_q[i] <= shadow_d[i];
                active_q[i] <= active_d[i];
            end
        end
    end

    assign pwm_out      = pwm_q;
    assign period_start = ps_q;
endmodule

// File: tb/tb_servo_pwm_multi.sv
// Directed bench for servo_pwm_multi: clamping, boundary-aligned updates, handshake stall, truncation, reset.
module tb_servo_pwm_multi;
    localparam int NCH = 4;
    localparam int CHW = 3;
    localparam int CW  = 8;
    localparam int PER = 100;

`ifdef SERVO_PWM_RAMP_EN
    localparam int E_P2_0 = 35;
    localparam int E_P3_0 = 40;
    localparam int E_P4_1 = 15;
`else
    localparam int E_P2_0 = 42;
    localparam int E_P3_0 = 42;
    localparam int E_P4_1 = 20;
`endif

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           enable = 1'b0;
    logic [NCH-1:0] pwm_out;
    logic           period_start;
    int             total = 0;
    int             bad = 0;

    servo_pwm_multi_if #(.CH_W(CHW), .CNT_W(CW)) wr_if ();

    servo_pwm_multi #(
        .NUM_CH(NCH), .CH_W(CHW), .CNT_W(CW), .PERIOD(PER),
        .MIN_PW(10), .MAX_PW(50), .RAMP_STEP(5)
    ) u_dut (
        .clk(clk),
        .rst_n(rst_n),
        .enable(enable),
        .wr(wr_if.slave),
        .pwm_out(pwm_out),
        .period_start(period_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wr_idle(input logic [CHW-1:0] ch, input int d);
        chk("ready_idle", wr_if.wr_ready, 1);
        wr_if.wr_valid = 1'b1;
        wr_if.wr_ch    = ch;
        wr_if.wr_data  = d[CW-1:0];
        @(negedge clk);
        wr_if.wr_valid = 1'b0;
    endtask

    task automatic wait_ps();
        int n = 0;
        while (!period_start && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("ps_found", period_start, 1);
    endtask

    // Entered on the negedge where period_start is high; returns on the next one.
    task automatic measure(input int e0, input int e1, input int e2, input int e3,
                           input bit wen, input int wk, input logic [CHW-1:0] wch,
                           input int wdata, input int exp_acc);
        int hi [NCH];
        int exp_hi [NCH];
        int acc_k = -1;
        int ps_extra = 0;
        exp_hi[0] = e0; exp_hi[1] = e1; exp_hi[2] = e2; exp_hi[3] = e3;
        for (int j = 0; j < NCH; j++) hi[j] = 0;
        chk("ps_at_start", period_start, 1);
        chk("ch0_first_cycle", pwm_out[0], (e0 != 0));
        for (int k = 0; k < PER; k++) begin
            for (int j = 0; j < NCH; j++) if (pwm_out[j]) hi[j]++;
            if (k > 0 && period_start) ps_extra++;
            chk($sformatf("wr_ready_k%0d", k), wr_if.wr_ready, (k != PER - 2));
            if (wen && acc_k < 0 && k >= wk) begin
                wr_if.wr_valid = 1'b1;
                wr_if.wr_ch    = wch;
                wr_if.wr_data  = wdata[CW-1:0];
                if (wr_if.wr_ready) acc_k = k;
            end else begin
                wr_if.wr_valid = 1'b0;
            end
            @(negedge clk);
        end
        wr_if.wr_valid = 1'b0;
        chk("ps_extra", ps_extra, 0);
        chk("ps_next_period", period_start, 1);
        for (int j = 0; j < NCH; j++) chk($sformatf("high_ch%0d", j), hi[j], exp_hi[j]);
        if (wen) chk("accept_k", acc_k, exp_acc);
    endtask

    initial begin
        wr_if.wr_valid = 1'b0;
        wr_if.wr_ch    = '0;
        wr_if.wr_data  = '0;
        repeat (3) @(negedge clk);
        chk("rst_pwm", pwm_out, 0);
        chk("rst_ps", period_start, 0);
        chk("rst_ready", wr_if.wr_ready, 1);
        rst_n = 1'b1;
        @(negedge clk);

        wr_idle(0, 30);
        wr_idle(1, 3);
        wr_idle(2, 80);
        wr_idle(3, 0);
        repeat (3) @(negedge clk);
        chk("idle_pwm", pwm_out, 0);

        enable = 1'b1;
        wait_ps();
        measure(30, 10, 50, 0, 1'b1, 19, 0, 42, 19);
        measure(E_P2_0, 10, 50, 0, 1'b1, 98, 1, 20, 99);
        measure(E_P3_0, 10, 50, 0, 1'b1, 30, 5, 25, 30);
        measure(42, E_P4_1, 50, 0, 1'b0, 0, 0, 0, 0);
        measure(42, 20, 50, 0, 1'b1, 10, 0, 0, 10);
        measure(0, 20, 50, 0, 1'b1, 5, 0, 30, 5);

        repeat (14) @(negedge clk);
        chk("trunc_before", pwm_out[0], 1);
        enable = 1'b0;
        @(negedge clk);
        chk("trunc_pwm", pwm_out, 0);
        chk("trunc_ps", period_start, 0);
        repeat (5) @(negedge clk);
        chk("idle_after_trunc", pwm_out, 0);

        enable = 1'b1;
        wait_ps();
        repeat (5) @(negedge clk);
        chk("pre_reset_pwm", pwm_out, 4'b0111);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_pwm", pwm_out, 0);
        chk("async_rst_ready", wr_if.wr_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        wait_ps();
        measure(0, 0, 0, 0, 1'b0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
